// File: rtl/robertson_mult_param.sv
// robertson_mult_param: WIDTH-bit sequential add/shift multiplier with valid/ready handshakes,
// signed (Robertson correction) or unsigned per operation. Define ROBERTSON_ZERO_SKIP_EN for zero-operand bypass.

module robertson_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic             f_reg;
    logic             mode_reg;
    logic [CW-1:0]    count;
    logic             last_iter;
    logic             zero_ops;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;

    assign last_iter = (count == CW'(WIDTH - 1));
    assign product   = {a_reg, q_reg};

`ifdef ROBERTSON_ZERO_SKIP_EN
    assign zero_ops = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_ops = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = zero_ops ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // {F,A} is the partial product at WIDTH+1 bits; the last signed step subtracts M (sign weight of Q).
    always_comb begin
        acc_ext = {mode_reg & f_reg, a_reg};
        addend  = '0;
        if (q_reg[0]) begin
            addend = {mode_reg & m_reg[WIDTH-1], m_reg};
            if (mode_reg && last_iter) begin
                addend = ~addend + ONE;
            end
        end
        sum = acc_ext + addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            q_reg    <= '0;
            m_reg    <= '0;
            f_reg    <= 1'b0;
            mode_reg <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg    <= multiplicand;
                        q_reg    <= zero_ops ? '0 : multiplier;
                        mode_reg <= signed_mode;
                        a_reg    <= '0;
                        f_reg    <= 1'b0;
                        count    <= '0;
                    end
                end
                RUN: begin
                    a_reg <= sum[WIDTH:1];
                    q_reg <= {sum[0], q_reg[WIDTH-1:1]};
                    f_reg <= sum[WIDTH];
                    count <= count + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_robertson_mult_param.sv
// Scoreboard testbench for robertson_mult_param: WIDTH=8 and WIDTH=16 instances against an arithmetic model.
// Honours ROBERTSON_ZERO_SKIP_EN for the expected latency of zero-operand multiplies.

module tb_robertson_mult_param;

    localparam int W  = 8;
    localparam int W2 = 16;

`ifdef ROBERTSON_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    typedef struct {
        logic [63:0] prod;
        int          accept_cyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [W-1:0]    multiplicand, multiplier;
    logic [2*W-1:0]  product;

    logic            in_valid16, in_ready16, signed_mode16, out_valid16, busy16;
    logic            out_ready16 = 1'b1;
    logic [W2-1:0]   multiplicand16, multiplier16;
    logic [2*W2-1:0] product16;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 2;
    exp_t sb8[$];
    exp_t sb16[$];

    robertson_mult_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    robertson_mult_param #(.WIDTH(W2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .multiplicand(multiplicand16), .multiplier(multiplier16), .signed_mode(signed_mode16),
        .out_valid(out_valid16), .out_ready(out_ready16), .product(product16), .busy(busy16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q,
                                            input logic s, input int w);
        longint mi, qi;
        longint unsigned mask;
        mi = longint'(m);
        qi = longint'(q);
        if (s) begin
            if (m[w-1]) mi = mi - (longint'(1) << w);
            if (q[w-1]) qi = qi - (longint'(1) << w);
        end
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(mi * qi) & 64'(mask);
    endfunction

    function automatic int exp_lat(input logic [31:0] m, input logic [31:0] q, input int w);
        return (ZSKIP && (m == 0 || q == 0)) ? 1 : w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        multiplicand = m;
        multiplier   = q;
        signed_mode  = s;
        in_valid     = 1'b1;
        sb8.push_back('{ref_mul(32'(m), 32'(q), s, W), cyc + 1, exp_lat(32'(m), 32'(q), W)});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus16(input logic [W2-1:0] m, input logic [W2-1:0] q, input logic s);
        int waited = 0;
        while (!in_ready16 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready16) begin
            checkOutput("in_ready16_timeout", 64'(in_ready16), 64'd1);
            return;
        end
        multiplicand16 = m;
        multiplier16   = q;
        signed_mode16  = s;
        in_valid16     = 1'b1;
        sb16.push_back('{ref_mul(32'(m), 32'(q), s, W2), cyc + 1, exp_lat(32'(m), 32'(q), W2)});
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 8'h80;
            2:       return 8'h7F;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitors: compare every presented product with the queue head, pop on the output handshake.
    logic prev_ov8 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov8 = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb8.size() == 0) begin
                    checkOutput("unexpected_out8", 64'(out_valid), 64'd0);
                end else begin
                    if (!prev_ov8) checkOutput("latency8", 64'(cyc - sb8[0].accept_cyc), 64'(sb8[0].lat));
                    checkOutput("product8", 64'(product), sb8[0].prod);
                    if (out_ready) void'(sb8.pop_front());
                end
            end
            prev_ov8 = out_valid;
        end
    end

    logic prev_ov16 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov16 = 1'b0;
        end else begin
            if (out_valid16) begin
                if (sb16.size() == 0) begin
                    checkOutput("unexpected_out16", 64'(out_valid16), 64'd0);
                end else begin
                    if (!prev_ov16) checkOutput("latency16", 64'(cyc - sb16[0].accept_cyc), 64'(sb16[0].lat));
                    checkOutput("product16", 64'(product16), sb16[0].prod);
                    if (out_ready16) void'(sb16.pop_front());
                end
            end
            prev_ov16 = out_valid16;
        end
    end

    initial begin
        int busy_cnt;
        int waited;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0; multiplicand = '0; multiplier = '0; signed_mode = 1'b0;
        in_valid16 = 1'b0; multiplicand16 = '0; multiplier16 = '0; signed_mode16 = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_product", 64'(product), 64'd0);
        rst = 1'b0;

        // -3 * 5 signed, busy for WIDTH+1 cycles with out_ready high.
        applyStimulus(8'hFD, 8'h05, 1'b1);
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            else break;
        end
        checkOutput("busy_cycles", 64'(busy_cnt), 64'(W + 1));
        @(posedge clk); #1;

        applyStimulus(8'h80, 8'h80, 1'b1);
        applyStimulus(8'h7F, 8'hFF, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        applyStimulus(8'h01, 8'h80, 1'b1);

        // Backpressure: result held in DONE, new operands ignored.
        waited = 0;
        while (!in_ready && waited < 200) begin @(posedge clk); #1; waited++; end
        ready_mode = 1;
        out_ready  = 1'b0;
        applyStimulus(8'h12, 8'h34, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        checkOutput("bp_reach_done", 64'(seen), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            multiplicand = 8'h05; multiplier = 8'h06; signed_mode = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        ready_mode = 2;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset during RUN at iteration 3 discards the operation.
        applyStimulus(8'h07, 8'h09, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb8.delete();
        sb16.delete();
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_product", 64'(product), 64'd0);
        applyStimulus(8'd6, 8'd7, 1'b0);

        // Randomised traffic with random output backpressure.
        ready_mode = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        ready_mode = 2;

        applyStimulus16(16'h8000, 16'h7FFF, 1'b1);
        applyStimulus16(16'h0000, 16'h1234, 1'b1);
        applyStimulus16(16'h8000, 16'h8000, 1'b1);
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus16(W2'($urandom), W2'($urandom), 1'($urandom_range(0, 1)));
        end

        waited = 0;
        while ((sb8.size() != 0 || sb16.size() != 0) && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("drain8", 64'(sb8.size()), 64'd0);
        checkOutput("drain16", 64'(sb16.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
